// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encodings.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; result, borrow and signed overflow
// are published together when the last bit completes and then held.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_busy_next;
    logic             w_done_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic             w_accept;
    logic             w_run;
    logic             w_last;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_next)
    );

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == CNT_LAST);

    // State register with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            busy    <= w_busy_next;
            done    <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_LAST) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the upcoming state so they line up with it
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        if (w_state_next == ST_RUN)  w_busy_next = 1'b1;
        if (w_state_next == ST_DONE) w_done_next = 1'b1;
    end

    // Operand shifters, borrow, counter; results update only on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_acc <= {w_d, r_acc[WIDTH-1:1]};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                diff <= {w_d, r_acc[WIDTH-1:1]};
                bout <= w_br_next;
                ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend (unsigned/two's complement); captured on start acceptance.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend; captured on start acceptance.
REQ-007 SHALL have port: busy  output  1  high while the operation is in progress (state RUN).
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 SHALL have port: bout  output  1  final borrow; 1 iff a < b (unsigned).
REQ-011 SHALL have port: ovf  output  1  signed overflow of a - b.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at an edge SHALL: capture a and b into shift registers; clear the borrow flop and the bit counter; go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 RUN SHALL process one bit per edge, LSB first, using the following logic:
- d = a0 ^ b0 ^ br.
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
- d is shifted into diff from the MSB end.
- Both operand registers shift right by one.
REQ-016 After exactly WIDTH RUN edges, the FSM SHALL enter DONE.
REQ-017 Latency: done SHALL be high exactly WIDTH+1 cycles after the start-accepting edge; for WIDTH=8, done is high in the 9th cycle.
REQ-018 DONE SHALL last one cycle with done=1; bout = final br; ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using captured operand MSBs. The FSM SHALL then return to IDLE.
REQ-019 start asserted in RUN or DONE SHALL be ignored; there is no queuing. A start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-020 Changes on a or b after acceptance SHALL have no effect on the result.
REQ-021 diff, bout and ovf SHALL hold their values from DONE until the next start acceptance.
REQ-022 diff, bout and ovf may change during RUN; they are valid only when done=1 or afterwards in IDLE.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-024 Boundary: a == b SHALL yield diff=0, bout=0, ovf=0. b=0 SHALL yield diff=a, bout=0.

Reset
REQ-025 rst=1 at an edge SHALL force:
- state IDLE;
- busy=0, done=0, diff=0, bout=0, ovf=0;
- counter, borrow and operand registers to 0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation without producing a done pulse.
REQ-027 rst SHALL have priority over start on the same edge.

Structure
REQ-028 FSM state encodings (IDLE/RUN/DONE) SHALL be defined as shared constants in the lab's common definitions package, alongside the default WIDTH.
REQ-029 The per-bit borrow logic SHALL be a combinational sub-module full_subtractor: inputs x, y, bin; outputs d, bout. It is instantiated once.
REQ-030 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL saturate safely without wrapping to a false DONE.

Verification
REQ-031 WIDTH=8, a=0x05, b=0x03, start one cycle -> busy for 8 cycles; done in cycle 9; diff=0x02, bout=0, ovf=0.
REQ-032 a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0; a=0x00, b=0x01 -> diff=0xFF, bout=1.
REQ-033 a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0; a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
REQ-034 Start pulse at RUN cycle 3 with new operands, and a/b toggled mid-run -> first result unchanged; exactly one done pulse.
REQ-035 rst asserted at RUN cycle 4 -> next cycle IDLE with all outputs 0 and no done pulse; a following start 0x10-0x0F -> diff=0x01.
REQ-036 start held high continuously -> successive done pulses every WIDTH+2 cycles; diff stable between pulses.
